matrix_generator_lfsr: RTL and testbench
========================================

MATRIX_GENERATOR_LFSR -- requirements
Module: matrix_generator_lfsr

Interface
REQ-001 Parameter NUMBER_OF_TABLES, default 4, number of hash tables (>=1).
REQ-002 Parameter HASH_ADR_WIDTH, default 5, rows per matrix (one row per address bit).
REQ-003 Parameter KEY_WIDTH, default 6, row width in bits (<= LFSR_WIDTH).
REQ-004 Parameter LFSR_WIDTH, default 32, LFSR state width.
REQ-005 Parameter POLY, default 32'h80200003, Galois feedback mask.
REQ-006 Parameter SEED, default 32'hACE12468, reset seed, nonzero.
REQ-007 clk  in  1  single clock, all logic rising-edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 regen_i  in  1  request to generate a new matrix set.
REQ-010 abort_i  in  1  cancel a generation in progress.
REQ-011 seed_i  in  LFSR_WIDTH  new LFSR seed.
REQ-012 seed_valid_i  in  1  load seed_i.
REQ-013 busy_o  out  1  generation in progress.
REQ-014 done_o  out  1  one-cycle pulse on commit.
REQ-015 matrixes_o  out  NUMBER_OF_TABLES*HASH_ADR_WIDTH*KEY_WIDTH  live matrices; table t row r at bit offset (t*HASH_ADR_WIDTH+r)*KEY_WIDTH.

Function
REQ-016 The block SHALL hold a live matrix bank driving matrixes_o and a shadow bank for generation; matrixes_o SHALL change only on reset, commit or (if enabled) direct write.
REQ-017 FSM states SHALL be IDLE, GEN, COMMIT; IDLE->GEN on regen_i; GEN->COMMIT after the last row is written; COMMIT->IDLE unconditionally; GEN->IDLE on abort_i.
REQ-018 Per GEN cycle the LFSR SHALL advance KEY_WIDTH Galois steps (lsb=1: state=(state>>1)^POLY, else state>>1); candidate row = low KEY_WIDTH bits of the new state.
REQ-019 A nonzero candidate SHALL be written to shadow[t][r] and advance r, then t (r wraps at HASH_ADR_WIDTH-1 to 0); an all-zero candidate SHALL be discarded without advancing counters.
REQ-020 In COMMIT the shadow bank SHALL be copied to the live bank and done_o asserted for that one cycle; matrixes_o shows new values from the cycle after COMMIT.
REQ-021 Latency from regen_i accepted (cycle 0) to done_o SHALL be NUMBER_OF_TABLES*HASH_ADR_WIDTH + Z + 1 cycles, Z = discarded zero rows.
REQ-022 busy_o SHALL be high exactly in GEN and COMMIT; regen_i and seed_valid_i SHALL be ignored while busy_o is high.
REQ-023 seed_valid_i in IDLE SHALL load seed_i; seed_i==0 SHALL load SEED instead (lockup guard).
REQ-024 seed_valid_i and regen_i together in IDLE: seed loads that cycle, GEN starts next cycle using the new seed.
REQ-025 abort_i in GEN SHALL return to IDLE next cycle, keep live bank unchanged, no done_o, LFSR keeps its current state; abort_i outside GEN SHALL be ignored; abort_i has priority over GEN completion.

Reset
REQ-026 Reset SHALL force IDLE, busy_o=0, done_o=0, LFSR=SEED, counters=0.
REQ-027 Reset SHALL set live and shadow row r of every table to 1<<(r mod KEY_WIDTH), truncated to KEY_WIDTH.
REQ-028 Reset mid-GEN SHALL discard the generation and restore REQ-026/027 values immediately (asynchronously).

Configuration
REQ-029 With MATRIX_GEN_LOAD_EN defined, ports wr_en_i (1), wr_table_i (ceil(log2 NUMBER_OF_TABLES), min 1), wr_row_i (ceil(log2 HASH_ADR_WIDTH), min 1), wr_data_i (KEY_WIDTH) SHALL exist; wr_en_i in IDLE writes wr_data_i to live[wr_table_i][wr_row_i] next edge; ignored when busy_o high or indices out of range.
REQ-030 Without MATRIX_GEN_LOAD_EN those ports SHALL not exist and the live bank changes only by reset and commit.

Verification
REQ-031 Reset, default params -> each 30-bit table slice of matrixes_o = 0x10204081, busy_o=0, done_o=0.
REQ-032 regen_i one cycle after reset -> busy_o high, done_o pulse at cycle 21 + Z, matrixes_o matches a software model of REQ-018/019 seeded 0xACE12468, no zero rows.
REQ-033 seed_valid_i with seed_i=0 plus regen_i same cycle -> output identical to REQ-032 run (SEED substituted).
REQ-034 abort_i at GEN cycle 7 -> IDLE next cycle, no done_o, matrixes_o still 0x10204081 per table; next regen_i continues from the unchanged LFSR state.
REQ-035 reset asserted at GEN cycle 10 -> immediate defaults; regen_i again reproduces REQ-032 result exactly.
REQ-036 With MATRIX_GEN_LOAD_EN, write table 2 row 3 = 6'h2A in IDLE -> bits [(2*5+3)*6 +: 6] = 6'h2A next cycle; same write while busy_o high -> no change.

Source files
------------

// File: rtl/matrix_generator_lfsr.sv
// rtl/matrix_generator_lfsr.sv - LFSR-driven hash matrix generator with shadow/live banks (optional direct write: MATRIX_GEN_LOAD_EN)
module matrix_generator_lfsr #(
    parameter int NUMBER_OF_TABLES = 4,
    parameter int HASH_ADR_WIDTH   = 5,
    parameter int KEY_WIDTH        = 6,
    parameter int LFSR_WIDTH       = 32,
    parameter logic [LFSR_WIDTH-1:0] POLY = 32'h80200003,
    parameter logic [LFSR_WIDTH-1:0] SEED = 32'hACE12468
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  regen_i,
    input  logic                  abort_i,
    input  logic [LFSR_WIDTH-1:0] seed_i,
    input  logic                  seed_valid_i,
`ifdef MATRIX_GEN_LOAD_EN
    input  logic                  wr_en_i,
    input  logic [((NUMBER_OF_TABLES > 1) ? $clog2(NUMBER_OF_TABLES) : 1)-1:0] wr_table_i,
    input  logic [((HASH_ADR_WIDTH > 1) ? $clog2(HASH_ADR_WIDTH) : 1)-1:0]     wr_row_i,
    input  logic [KEY_WIDTH-1:0]  wr_data_i,
`endif
    output logic                  busy_o,
    output logic                  done_o,
    output logic [NUMBER_OF_TABLES*HASH_ADR_WIDTH*KEY_WIDTH-1:0] matrixes_o
);

    localparam int ROWS = NUMBER_OF_TABLES * HASH_ADR_WIDTH;
    localparam int TW   = (NUMBER_OF_TABLES > 1) ? $clog2(NUMBER_OF_TABLES) : 1;
    localparam int RW   = (HASH_ADR_WIDTH > 1) ? $clog2(HASH_ADR_WIDTH) : 1;
    localparam int IW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [TW-1:0] LAST_T = TW'(NUMBER_OF_TABLES - 1);
    localparam logic [RW-1:0] LAST_R = RW'(HASH_ADR_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GEN    = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                state;
    logic [LFSR_WIDTH-1:0] lfsr;
    logic [LFSR_WIDTH-1:0] lfsr_next;
    logic [KEY_WIDTH-1:0]  cand;
    logic [TW-1:0]         t_cnt;
    logic [RW-1:0]         r_cnt;
    logic [IW-1:0]         gen_idx;
    logic [KEY_WIDTH-1:0]  live   [ROWS];
    logic [KEY_WIDTH-1:0]  shadow [ROWS];

    // One GEN cycle consumes KEY_WIDTH Galois steps of the LFSR
    function automatic logic [LFSR_WIDTH-1:0] lfsr_advance(input logic [LFSR_WIDTH-1:0] s);
        logic [LFSR_WIDTH-1:0] v;
        v = s;
        for (int k = 0; k < KEY_WIDTH; k++) begin
            v = v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
        end
        return v;
    endfunction

    assign lfsr_next = lfsr_advance(lfsr);
    assign cand      = lfsr_next[KEY_WIDTH-1:0];
    assign gen_idx   = IW'(t_cnt) * IW'(HASH_ADR_WIDTH) + IW'(r_cnt);

`ifdef MATRIX_GEN_LOAD_EN
    logic [IW-1:0] wr_idx;
    logic          wr_ok;
    assign wr_idx = IW'(wr_table_i) * IW'(HASH_ADR_WIDTH) + IW'(wr_row_i);
    assign wr_ok  = wr_en_i && (int'(wr_table_i) < NUMBER_OF_TABLES) &&
                    (int'(wr_row_i) < HASH_ADR_WIDTH);
`endif

    // Live bank flattened onto the output bus, row index = t*HASH_ADR_WIDTH + r
    for (genvar i = 0; i < ROWS; i++) begin : g_out
        assign matrixes_o[i*KEY_WIDTH +: KEY_WIDTH] = live[i];
    end

    // Controller: state, LFSR, row counters, shadow fill, commit and registered status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            lfsr   <= SEED;
            t_cnt  <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < ROWS; i++) begin
                live[i]   <= KEY_WIDTH'(1) << ((i % HASH_ADR_WIDTH) % KEY_WIDTH);
                shadow[i] <= KEY_WIDTH'(1) << ((i % HASH_ADR_WIDTH) % KEY_WIDTH);
            end
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    // A zero seed would lock the LFSR, so fall back to SEED
                    if (seed_valid_i) begin
                        lfsr <= (seed_i == '0) ? SEED : seed_i;
                    end
                    if (regen_i) begin
                        state  <= GEN;
                        busy_o <= 1'b1;
                        t_cnt  <= '0;
                        r_cnt  <= '0;
                    end
`ifdef MATRIX_GEN_LOAD_EN
                    if (wr_ok) begin
                        live[wr_idx] <= wr_data_i;
                    end
`endif
                end
                GEN: begin
                    if (abort_i) begin
                        // Abort wins over completion; LFSR is left where it stands
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        lfsr <= lfsr_next;
                        if (cand != '0) begin
                            shadow[gen_idx] <= cand;
                            if (t_cnt == LAST_T && r_cnt == LAST_R) begin
                                state  <= COMMIT;
                                done_o <= 1'b1;
                                t_cnt  <= '0;
                                r_cnt  <= '0;
                            end else if (r_cnt == LAST_R) begin
                                r_cnt <= '0;
                                t_cnt <= t_cnt + 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < ROWS; i++) begin
                        live[i] <= shadow[i];
                    end
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_generator_lfsr.sv
// tb/tb_matrix_generator_lfsr.sv - scoreboard bench for matrix_generator_lfsr
module tb_matrix_generator_lfsr;

    localparam int NT   = 4;
    localparam int HA   = 5;
    localparam int KW   = 6;
    localparam int LW   = 32;
    localparam int MW   = NT * HA * KW;
    localparam logic [LW-1:0] POLY = 32'h80200003;
    localparam logic [LW-1:0] SEED = 32'hACE12468;
    localparam logic [MW-1:0] DEF_BANK = {4{30'h10204081}};

    logic          clk = 1'b0;
    logic          reset;
    logic          regen_i;
    logic          abort_i;
    logic [LW-1:0] seed_i;
    logic          seed_valid_i;
    logic          busy_o;
    logic          done_o;
    logic [MW-1:0] matrixes_o;
`ifdef MATRIX_GEN_LOAD_EN
    logic          wr_en_i;
    logic [1:0]    wr_table_i;
    logic [2:0]    wr_row_i;
    logic [KW-1:0] wr_data_i;
`endif

    matrix_generator_lfsr dut (
        .clk          (clk),
        .reset        (reset),
        .regen_i      (regen_i),
        .abort_i      (abort_i),
        .seed_i       (seed_i),
        .seed_valid_i (seed_valid_i),
`ifdef MATRIX_GEN_LOAD_EN
        .wr_en_i      (wr_en_i),
        .wr_table_i   (wr_table_i),
        .wr_row_i     (wr_row_i),
        .wr_data_i    (wr_data_i),
`endif
        .busy_o       (busy_o),
        .done_o       (done_o),
        .matrixes_o   (matrixes_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MW-1:0] mats;
        int            lat;
    } exp_t;

    exp_t          sb[$];
    int            total_cnt = 0;
    int            pass_cnt  = 0;
    logic [LW-1:0] mstate;
    logic [MW-1:0] live_model;

    function automatic logic [LW-1:0] galois(input logic [LW-1:0] s);
        if (s[0]) return (s >> 1) ^ POLY;
        return s >> 1;
    endfunction

    // Reference generation from mstate; pushes the expected bank and latency
    task automatic push_exp();
        exp_t          e;
        logic [KW-1:0] c;
        int            z;
        int            idx;
        e.mats = '0;
        z      = 0;
        idx    = 0;
        while (idx < NT * HA) begin
            for (int k = 0; k < KW; k++) mstate = galois(mstate);
            c = mstate[KW-1:0];
            if (c == '0) z++;
            else begin
                e.mats[idx*KW +: KW] = c;
                idx++;
            end
        end
        e.lat = NT * HA + z + 1;
        sb.push_back(e);
    endtask

    task automatic start_gen(input logic with_seed, input logic [LW-1:0] seed);
        regen_i      = 1'b1;
        seed_valid_i = with_seed;
        seed_i       = seed;
        @(negedge clk);
        regen_i      = 1'b0;
        seed_valid_i = 1'b0;
        seed_i       = '0;
    endtask

    // Counts cycles (regen cycle = 0) until done_o is seen; -1 on timeout
    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (!done_o && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        if (!done_o) lat = -1;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        mstate     = SEED;
        live_model = DEF_BANK;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        for (int t = 0; t < NT; t++) begin
            total_cnt++;
            if (matrixes_o[t*30 +: 30] !== 30'h10204081)
                $display("FAIL reset_slice%0d actual=%h expected=%h", t, matrixes_o[t*30 +: 30], 30'h10204081);
            else pass_cnt++;
        end
        reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (busy_o !== 1'b0) $display("FAIL reset_busy actual=%b expected=0", busy_o);
        else pass_cnt++;
        total_cnt++;
        if (done_o !== 1'b0) $display("FAIL reset_done actual=%b expected=0", done_o);
        else pass_cnt++;
        mstate     = SEED;
        live_model = DEF_BANK;
    endtask

    task automatic test_regen();
        exp_t e;
        int   lat;
        push_exp();
        start_gen(1'b0, '0);
        total_cnt++;
        if (busy_o !== 1'b1) $display("FAIL regen_busy actual=%b expected=1", busy_o);
        else pass_cnt++;
        wait_done(1, lat);
        e = sb.pop_front();
        total_cnt++;
        if (lat !== e.lat) $display("FAIL regen_latency actual=%0d expected=%0d", lat, e.lat);
        else pass_cnt++;
        total_cnt++;
        if (matrixes_o !== live_model) $display("FAIL regen_commit_old actual=%h expected=%h", matrixes_o, live_model);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (matrixes_o !== e.mats) $display("FAIL regen_mats actual=%h expected=%h", matrixes_o, e.mats);
        else pass_cnt++;
        total_cnt++;
        if (done_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL regen_after actual=done%b/busy%b expected=done0/busy0", done_o, busy_o);
        else pass_cnt++;
        live_model = e.mats;
    endtask

    task automatic test_seed_zero();
        exp_t e;
        int   lat;
        do_reset();
        push_exp();
        start_gen(1'b1, '0);
        wait_done(1, lat);
        e = sb.pop_front();
        total_cnt++;
        if (lat !== e.lat) $display("FAIL seed0_latency actual=%0d expected=%0d", lat, e.lat);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (matrixes_o !== e.mats) $display("FAIL seed0_mats actual=%h expected=%h", matrixes_o, e.mats);
        else pass_cnt++;
        live_model = e.mats;
    endtask

    task automatic test_reset_mid_gen();
        exp_t e;
        int   lat;
        start_gen(1'b0, '0);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if (busy_o !== 1'b0) $display("FAIL midrst_busy actual=%b expected=0", busy_o);
        else pass_cnt++;
        total_cnt++;
        if (matrixes_o !== DEF_BANK) $display("FAIL midrst_mats actual=%h expected=%h", matrixes_o, DEF_BANK);
        else pass_cnt++;
        @(negedge clk);
        reset      = 1'b0;
        mstate     = SEED;
        live_model = DEF_BANK;
        push_exp();
        start_gen(1'b0, '0);
        wait_done(1, lat);
        e = sb.pop_front();
        total_cnt++;
        if (lat !== e.lat) $display("FAIL midrst_latency actual=%0d expected=%0d", lat, e.lat);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (matrixes_o !== e.mats) $display("FAIL midrst_regen_mats actual=%h expected=%h", matrixes_o, e.mats);
        else pass_cnt++;
        live_model = e.mats;
    endtask

    task automatic test_abort();
        exp_t e;
        int   lat;
        logic seen;
        do_reset();
        start_gen(1'b0, '0);
        repeat (6) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        for (int k = 0; k < 6 * KW; k++) mstate = galois(mstate);
        total_cnt++;
        if (busy_o !== 1'b0) $display("FAIL abort_busy actual=%b expected=0", busy_o);
        else pass_cnt++;
        seen = 1'b0;
        repeat (25) begin
            if (done_o) seen = 1'b1;
            @(negedge clk);
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL abort_no_done actual=%b expected=0", seen);
        else pass_cnt++;
        total_cnt++;
        if (matrixes_o !== DEF_BANK) $display("FAIL abort_mats actual=%h expected=%h", matrixes_o, DEF_BANK);
        else pass_cnt++;
        push_exp();
        start_gen(1'b0, '0);
        wait_done(1, lat);
        e = sb.pop_front();
        total_cnt++;
        if (lat !== e.lat) $display("FAIL abort_resume_latency actual=%0d expected=%0d", lat, e.lat);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (matrixes_o !== e.mats) $display("FAIL abort_resume_mats actual=%h expected=%h", matrixes_o, e.mats);
        else pass_cnt++;
        live_model = e.mats;
    endtask

    task automatic test_busy_ignore();
        exp_t e;
        int   lat;
        push_exp();
        start_gen(1'b0, '0);
        repeat (3) @(negedge clk);
        regen_i      = 1'b1;
        seed_valid_i = 1'b1;
        seed_i       = 32'h0F0F0F0F;
        @(negedge clk);
        regen_i      = 1'b0;
        seed_valid_i = 1'b0;
        seed_i       = '0;
        wait_done(5, lat);
        e = sb.pop_front();
        total_cnt++;
        if (lat !== e.lat) $display("FAIL busyign_latency actual=%0d expected=%0d", lat, e.lat);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (matrixes_o !== e.mats) $display("FAIL busyign_mats actual=%h expected=%h", matrixes_o, e.mats);
        else pass_cnt++;
        live_model = e.mats;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        push_exp();
        start_gen(1'b0, '0);
        wait_done(1, lat);
        e = sb.pop_front();
        total_cnt++;
        if (lat !== e.lat) $display("FAIL b2b_latency actual=%0d expected=%0d", lat, e.lat);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (matrixes_o !== e.mats) $display("FAIL b2b_mats actual=%h expected=%h", matrixes_o, e.mats);
        else pass_cnt++;
        live_model = e.mats;
    endtask

    task automatic test_seed_load();
        exp_t e;
        int   lat;
        mstate = 32'h12345678;
        push_exp();
        abort_i = 1'b1;
        start_gen(1'b1, 32'h12345678);
        abort_i = 1'b0;
        wait_done(1, lat);
        e = sb.pop_front();
        total_cnt++;
        if (lat !== e.lat) $display("FAIL seedld_latency actual=%0d expected=%0d", lat, e.lat);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (matrixes_o !== e.mats) $display("FAIL seedld_mats actual=%h expected=%h", matrixes_o, e.mats);
        else pass_cnt++;
        live_model = e.mats;
    endtask

`ifdef MATRIX_GEN_LOAD_EN
    task automatic test_load();
        exp_t          e;
        int            lat;
        logic [MW-1:0] exp_l;
        do_reset();
        exp_l = DEF_BANK;
        exp_l[(2*5+3)*6 +: 6] = 6'h2A;
        wr_en_i = 1'b1; wr_table_i = 2'd2; wr_row_i = 3'd3; wr_data_i = 6'h2A;
        @(negedge clk);
        wr_en_i = 1'b0;
        total_cnt++;
        if (matrixes_o !== exp_l) $display("FAIL load_write actual=%h expected=%h", matrixes_o, exp_l);
        else pass_cnt++;
        wr_en_i = 1'b1; wr_table_i = 2'd1; wr_row_i = 3'd5; wr_data_i = 6'h3F;
        @(negedge clk);
        wr_en_i = 1'b0;
        total_cnt++;
        if (matrixes_o !== exp_l) $display("FAIL load_oob actual=%h expected=%h", matrixes_o, exp_l);
        else pass_cnt++;
        push_exp();
        start_gen(1'b0, '0);
        wr_en_i = 1'b1; wr_table_i = 2'd2; wr_row_i = 3'd3; wr_data_i = 6'h15;
        @(negedge clk);
        wr_en_i = 1'b0;
        total_cnt++;
        if (matrixes_o !== exp_l) $display("FAIL load_busy actual=%h expected=%h", matrixes_o, exp_l);
        else pass_cnt++;
        wait_done(2, lat);
        e = sb.pop_front();
        @(negedge clk);
        total_cnt++;
        if (matrixes_o !== e.mats) $display("FAIL load_commit_mats actual=%h expected=%h", matrixes_o, e.mats);
        else pass_cnt++;
        live_model = e.mats;
    endtask
`endif

    initial begin
        reset        = 1'b1;
        regen_i      = 1'b0;
        abort_i      = 1'b0;
        seed_i       = '0;
        seed_valid_i = 1'b0;
`ifdef MATRIX_GEN_LOAD_EN
        wr_en_i      = 1'b0;
        wr_table_i   = '0;
        wr_row_i     = '0;
        wr_data_i    = '0;
`endif
        test_reset();
        test_regen();
        test_seed_zero();
        test_reset_mid_gen();
        test_abort();
        test_busy_ignore();
        test_back_to_back();
        test_seed_load();
`ifdef MATRIX_GEN_LOAD_EN
        test_load();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
